// File: rtl/result_collector_pkg.sv
// Shared widths and the sign-magnitude to two's complement conversion
// used by the result collector and its FIFO.
package collector_pkg;

  localparam int RES_W = 13;
  localparam int OUT_W = 14;
  localparam logic [RES_W-1:0] NEG_ZERO = 13'h1000;

  // Negative zero is mapped explicitly so the output never carries a -0 encoding.
  function automatic logic [OUT_W-1:0] sm_to_tc(input logic [RES_W-1:0] sm);
    logic [OUT_W-1:0] mag;
    mag = {2'b00, sm[RES_W-2:0]};
    if (sm == NEG_ZERO) begin
      return '0;
    end
    return sm[RES_W-1] ? (~mag + 1'b1) : mag;
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// Valid/ready result port between the collector (master) and the consumer (slave).
interface result_collector_if;
  import collector_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/res_fifo.sv
// Synchronous FIFO with a registered head: a push into an empty FIFO shows up
// on dout/valid one cycle later, there is no combinational fall-through.
module res_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] head_reg;
  logic             valid_reg;
  logic             push_ok, pop_ok, bypass;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // The pushed word becomes the head when nothing else remains after this cycle's pop.
  assign bypass  = push_ok && (level_reg == LW'(pop_ok));

  always_comb begin
    wr_ptr_next = wr_ptr_reg + AW'(push_ok);
    rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
    level_next  = level_reg + LW'(push_ok) - LW'(pop_ok);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      valid_reg  <= (level_next != '0);
      if (!flush) begin
        if (bypass) begin
          head_reg <= din;
        end else if (pop_ok) begin
          head_reg <= mem[rd_ptr_next];
        end
      end
    end
  end

  assign dout  = head_reg;
  assign valid = valid_reg;
  assign level = level_reg;

endmodule

// File: rtl/result_collector.sv
// Catches datapath results LATENCY cycles after issue, converts them to two's
// complement, buffers them and counts accepted and dropped results.
module result_collector
  import collector_pkg::*;
#(
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   issue,
  input  logic [RES_W-1:0]       y,
  result_collector_if.master     result,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       acc_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow
);

  logic [1:0]         rst_sync_reg;
  logic               rst_int;
  logic [LATENCY-1:0] vp_reg;
  logic               tap, pop, push, drop, full, empty;
  logic [OUT_W-1:0]   tc_data;
  logic [CNT_W-1:0]   acc_cnt_reg, drop_cnt_reg;
  logic               overflow_reg;

  // Reset asserts immediately but is released two clock edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign rst_int = rst_sync_reg[1];

  generate
    if (LATENCY == 1) begin : g_vp_one
      always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
          vp_reg <= '0;
        end else begin
          vp_reg <= flush ? 1'b0 : issue;
        end
      end
    end else begin : g_vp_shift
      always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
          vp_reg <= '0;
        end else if (flush) begin
          vp_reg <= '0;
        end else begin
          vp_reg <= {vp_reg[LATENCY-2:0], issue};
        end
      end
    end
  endgenerate

  assign tap     = vp_reg[LATENCY-1];
  assign tc_data = sm_to_tc(y);
  assign pop     = result.out_valid && result.out_ready;
  // A result landing in a flush cycle vanishes without touching the counters.
  assign push    = tap && !flush && (!full || pop);
  assign drop    = tap && !flush && full && !pop;

  res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_int),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (tc_data),
    .dout  (result.out_data),
    .valid (result.out_valid),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      acc_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        acc_cnt_reg <= acc_cnt_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign acc_cnt  = acc_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_result_collector.sv
// Randomised and directed stimulus for result_collector, checked against a
// queue-based model of the issue-to-result timing and the FIFO.
module tb_result_collector;
  import collector_pkg::*;

  localparam int LATENCY = 6;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              issue = 1'b0;
  logic [RES_W-1:0]  y = '0;
  logic [3:0]        level;
  logic [CNT_W-1:0]  acc_cnt, drop_cnt;
  logic              overflow;

  result_collector_if res_if ();

  result_collector #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .issue    (issue),
    .y        (y),
    .result   (res_if),
    .level    (level),
    .acc_cnt  (acc_cnt),
    .drop_cnt (drop_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pend[$];
  logic [RES_W-1:0] ytag[$];
  logic [OUT_W-1:0] mq[$];
  int m_acc = 0;
  int m_drop = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_conv(input logic [RES_W-1:0] v);
    int m;
    m = int'(v[11:0]);
    if (v[12]) m = -m;
    return OUT_W'(m);
  endfunction

  task automatic check_state();
    chk("out_valid", 32'(res_if.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", 32'(res_if.out_data), 32'(mq[0]));
    chk("level", 32'(level), 32'(mq.size()));
    chk("acc_cnt", 32'(acc_cnt), 32'(m_acc));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input bit iss, input logic [RES_W-1:0] yv, input bit rdy, input bit fl);
    bit tap, pop, full;
    logic [RES_W-1:0] ycur;
    check_state();
    tap  = (pend.size() > 0) && (pend[0] == cyc);
    ycur = tap ? ytag[0] : RES_W'($urandom);
    y = ycur;
    issue = iss;
    res_if.out_ready = rdy;
    flush = fl;
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == DEPTH);
    if (fl) begin
      mq.delete();
      pend.delete();
      ytag.delete();
    end else begin
      if (tap) begin
        void'(pend.pop_front());
        void'(ytag.pop_front());
      end
      if (pop) void'(mq.pop_front());
      if (tap) begin
        if (!full || pop) begin
          mq.push_back(ref_conv(ycur));
          m_acc = (m_acc + 1) % (1 << CNT_W);
        end else begin
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
          m_ovf = 1'b1;
        end
      end
      if (iss) begin
        pend.push_back(cyc + LATENCY);
        ytag.push_back(yv);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    issue = 1'b0;
    flush = 1'b0;
    res_if.out_ready = 1'b0;
    mq.delete();
    pend.delete();
    ytag.delete();
    m_acc = 0;
    m_drop = 0;
    m_ovf = 1'b0;
    #1;
    chk("rst_valid", 32'(res_if.out_valid), 32'd0);
    chk("rst_data", 32'(res_if.out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_acc", 32'(acc_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    repeat (2) step(0, '0, 0, 0);
    rst = 1'b1;
    repeat (3) step(0, '0, 0, 0);
  endtask

  task automatic expect_one(input logic [RES_W-1:0] yv, input logic [OUT_W-1:0] exp);
    step(1, yv, 1, 0);
    for (int i = 0; i < 12 && !res_if.out_valid; i++) step(0, '0, 1, 0);
    chk("conv_seen", 32'(res_if.out_valid), 32'd1);
    chk("conv_data", 32'(res_if.out_data), 32'(exp));
    step(0, '0, 1, 0);
  endtask

  initial begin
    logic [RES_W-1:0] vals [10];
    res_if.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single result latency and value
    step(1, 13'h0005, 1, 0);
    repeat (5) step(0, '0, 1, 0);
    chk("t1_early", 32'(res_if.out_valid), 32'd0);
    step(0, '0, 1, 0);
    chk("t1_valid", 32'(res_if.out_valid), 32'd1);
    chk("t1_data", 32'(res_if.out_data), 32'h0005);
    chk("t1_acc", 32'(acc_cnt), 32'd1);
    step(0, '0, 1, 0);

    // Conversion corner cases
    expect_one(13'h1005, 14'h3FFB);
    expect_one(13'h1000, 14'h0000);
    expect_one(13'h1FFF, 14'h3001);
    expect_one(13'h0FFF, 14'h0FFF);

    // Overrun: 10 results into 8 slots, then drain in order
    do_reset();
    for (int i = 0; i < 10; i++) begin
      vals[i] = RES_W'($urandom);
      step(1, vals[i], 0, 0);
    end
    repeat (LATENCY + 1) step(0, '0, 0, 0);
    chk("t3_level", 32'(level), 32'd8);
    chk("t3_acc", 32'(acc_cnt), 32'd8);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    chk("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", 32'(res_if.out_data), 32'(ref_conv(vals[i])));
      step(0, '0, 1, 0);
    end
    chk("t3_empty", 32'(level), 32'd0);

    // Full FIFO with tap and pop in the same cycle
    for (int i = 0; i < 8; i++) step(1, RES_W'($urandom), 0, 0);
    repeat (LATENCY) step(0, '0, 0, 0);
    chk("t4_full", 32'(level), 32'd8);
    step(1, RES_W'($urandom), 0, 0);
    repeat (LATENCY - 1) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    chk("t4_level", 32'(level), 32'd8);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_acc", 32'(acc_cnt), 32'd17);

    // Reset mid-burst with 4 held and 3 in flight
    repeat (4) step(0, '0, 1, 0);
    repeat (3) step(1, RES_W'($urandom), 0, 0);
    chk("t5_held", 32'(level), 32'd4);
    do_reset();
    for (int i = 0; i < 2 * LATENCY; i++) begin
      chk("t5_stale", 32'(res_if.out_valid), 32'd0);
      step(0, '0, 1, 0);
    end

    // Flush with 5 held and a tap in the same cycle
    repeat (5) step(1, RES_W'($urandom), 0, 0);
    repeat (LATENCY) step(0, '0, 0, 0);
    chk("t6_held", 32'(level), 32'd5);
    step(1, RES_W'($urandom), 0, 0);
    repeat (LATENCY - 1) step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_valid", 32'(res_if.out_valid), 32'd0);
    chk("t6_acc", 32'(acc_cnt), 32'd5);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);

    // Random traffic with varying consumer pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        step(bit'($urandom_range(1, 0)), RES_W'($urandom),
             ($urandom_range(9, 0) < (ph * 4 + 2)), ($urandom_range(49, 0) == 0));
      end
    end
    check_state();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
